// File: rtl/range_pkg.sv
// Shared definitions for the ultrasonic ranging datapath: FSM encoding, 50 MHz timing
// defaults and the speed-of-sound constants used by the distance converter.
package range_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StHoldoff
    } state_t;

    localparam int unsigned DEF_TRIG_CYCLES      = 500;
    localparam int unsigned DEF_ECHO_WAIT_CYCLES = 1_500_000;
    localparam int unsigned DEF_MAX_ECHO_CYCLES  = 1_900_000;
    localparam int unsigned DEF_PERIOD_CYCLES    = 3_000_000;
    localparam int unsigned DEF_CNT_W            = 23;

    // distance = echo_cycles * SOUND_SPEED_M_S / SOUND_DIVISOR, scaled by the converter
    localparam int unsigned SOUND_SPEED_M_S = 343;
    localparam int unsigned SOUND_DIVISOR   = 100_000;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for the asynchronous echo pin plus single-cycle edge pulses.
module echo_sync (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_echo,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_echo;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ranging_sequencer.sv
// Ultrasonic rangefinder controller: trigger pulse, echo high-time measurement with
// timeouts, minimum re-trigger period and a one-cycle result strobe.
module ranging_sequencer
    import range_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES      = DEF_TRIG_CYCLES,
    parameter int unsigned ECHO_WAIT_CYCLES = DEF_ECHO_WAIT_CYCLES,
    parameter int unsigned MAX_ECHO_CYCLES  = DEF_MAX_ECHO_CYCLES,
    parameter int unsigned PERIOD_CYCLES    = DEF_PERIOD_CYCLES,
    parameter int unsigned CNT_W            = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             auto_en,
    input  logic             echo,
    output logic             trigger,
    output logic             busy,
    output logic [CNT_W-1:0] echo_cycles,
    output logic             result_valid,
    output logic             result_timeout
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ECHO_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_ECHO_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONES  = '1;
    // Leave HOLDOFF one cycle early so the IDLE->TRIG hop lands the next trigger rise
    // exactly PERIOD_CYCLES after the previous one.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PERIOD_CYCLES - 2);

    always_comb begin
        assert (64'(MAX_ECHO_CYCLES) < (64'd1 << CNT_W) &&
                64'(ECHO_WAIT_CYCLES) < (64'd1 << CNT_W) &&
                64'(PERIOD_CYCLES) < (64'd1 << CNT_W) &&
                PERIOD_CYCLES >= 2 && TRIG_CYCLES >= 1 && ECHO_WAIT_CYCLES >= 1)
        else $error("ranging_sequencer: timing parameter out of range for CNT_W");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   w_period_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_trigger;
    logic               w_trigger_nxt;
    logic [CNT_W-1:0]   r_echo_cycles;
    logic [CNT_W-1:0]   w_echo_cycles_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               w_rise;
    logic               w_fall;

    echo_sync u_echo_sync (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_echo    (echo),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_period      <= '0;
            r_cnt         <= '0;
            r_trigger     <= 1'b0;
            r_echo_cycles <= '0;
            r_timeout     <= 1'b0;
            r_valid       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_period      <= w_period_nxt;
            r_cnt         <= w_cnt_nxt;
            r_trigger     <= w_trigger_nxt;
            r_echo_cycles <= w_echo_cycles_nxt;
            r_timeout     <= w_timeout_nxt;
            r_valid       <= w_valid_nxt;
        end
    end

    // r_cnt is the wait counter in WAIT_RISE and the echo counter in MEASURE.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_echo_cycles_nxt = r_echo_cycles;
        w_timeout_nxt     = r_timeout;
        w_valid_nxt       = 1'b0;
        w_period_nxt      = (r_period == CNT_ONES) ? r_period : r_period + 1'b1;

        unique case (r_state)
            StIdle: begin
                w_period_nxt = '0;
                w_cnt_nxt    = '0;
                if (start || auto_en) begin
                    w_state_nxt = StTrig;
                end
            end
            StTrig: begin
                if (r_period >= TRIG_LAST) begin
                    w_state_nxt = StWaitRise;
                    w_cnt_nxt   = '0;
                end
            end
            StWaitRise: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_rise) begin
                    w_state_nxt = StMeasure;
                    w_cnt_nxt   = CNT_W'(1);
                end else if (r_cnt >= WAIT_LAST) begin
                    w_state_nxt       = StHoldoff;
                    w_echo_cycles_nxt = '0;
                    w_timeout_nxt     = 1'b1;
                    w_valid_nxt       = 1'b1;
                end
            end
            StMeasure: begin
                // A fall on the same cycle the count hits MAX is a valid result.
                if (w_fall) begin
                    w_state_nxt       = StHoldoff;
                    w_echo_cycles_nxt = r_cnt;
                    w_timeout_nxt     = 1'b0;
                    w_valid_nxt       = 1'b1;
                end else if (r_cnt >= MAX_CNT) begin
                    w_state_nxt       = StHoldoff;
                    w_echo_cycles_nxt = MAX_CNT;
                    w_timeout_nxt     = 1'b1;
                    w_valid_nxt       = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StHoldoff: begin
                if (r_period >= HOLD_LAST) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        w_trigger_nxt = (w_state_nxt == StTrig);
    end

    assign trigger        = r_trigger;
    assign busy           = (r_state != StIdle);
    assign echo_cycles    = r_echo_cycles;
    assign result_valid   = r_valid;
    assign result_timeout = r_timeout;

endmodule
